mem_arbiter: RTL and testbench

Two-port arbiter and sequencer for the 512x8 byte-addressed RAM. It shares the single memory port between an instruction-fetch requester (port 0) and a data requester (port 1). It drives the RAM's `memFuncActive`/`readWrite`/`address`/`dataIn`/`dataSize` handshake, waits for `memFuncComplete`, and returns read data zero-extended with a one-cycle acknowledge. It also bounds every access with a completion timeout.

---
 rtl/mem_arbiter_if.sv | 43 ++++
 rtl/mem_arbiter.sv | 143 ++++++++++++++
 tb/tb_mem_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: two requester ports plus the single RAM port.
// The slave modport is the arbiter's view; master is the requesters/RAM side.
interface mem_arbiter_if;
   logic        p0_req;
   logic        p1_req;
   logic        p0_rw;
   logic        p1_rw;
   logic [8:0]  p0_addr;
   logic [8:0]  p1_addr;
   logic [31:0] p0_wdata;
   logic [31:0] p1_wdata;
   logic [1:0]  p0_size;
   logic [1:0]  p1_size;
   logic        p0_ack;
   logic        p1_ack;
   logic [31:0] p0_rdata;
   logic [31:0] p1_rdata;
   logic        p0_err;
   logic        p1_err;
   logic        mem_active;
   logic        mem_rw;
   logic [8:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [1:0]  mem_size;
   logic [31:0] mem_rdata;
   logic        mem_complete;

   modport slave (
      input  p0_req, p1_req, p0_rw, p1_rw, p0_addr, p1_addr,
      input  p0_wdata, p1_wdata, p0_size, p1_size,
      output p0_ack, p1_ack, p0_rdata, p1_rdata, p0_err, p1_err,
      output mem_active, mem_rw, mem_addr, mem_wdata, mem_size,
      input  mem_rdata, mem_complete
   );

   modport master (
      output p0_req, p1_req, p0_rw, p1_rw, p0_addr, p1_addr,
      output p0_wdata, p1_wdata, p0_size, p1_size,
      input  p0_ack, p1_ack, p0_rdata, p1_rdata, p0_err, p1_err,
      input  mem_active, mem_rw, mem_addr, mem_wdata, mem_size,
      output mem_rdata, mem_complete
   );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin two-port arbiter/sequencer for the 512x8 RAM with completion timeout.
// Optional MEM_ARB_ALIGN_CHECK_EN rejects misaligned word/halfword accesses.
module mem_arbiter #(
   parameter int TIMEOUT = 16   // legal range 2..255
) (
   input  logic          Clk,
   input  logic          Reset,
   mem_arbiter_if.slave  bus
);
   typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, DONE = 2'd2} state_t;

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   state_t           state_reg;
   logic             lg_reg;
   logic             grant_reg;
   logic [7:0]       cnt_reg;
   logic             mem_active_reg;
   logic             mem_rw_reg;
   logic [8:0]       mem_addr_reg;
   logic [31:0]      mem_wdata_reg;
   logic [1:0]       mem_size_reg;
   logic [1:0]       ack_reg;
   logic [1:0]       err_reg;
   logic [1:0][31:0] rdata_reg;

   logic             winner_next;
   logic             sel_rw;
   logic [8:0]       sel_addr;
   logic [31:0]      sel_wdata;
   logic [1:0]       sel_size;
   logic             sel_invalid;
   logic [3:0]       lane_keep;
   logic [31:0]      rdata_masked;

   // On contention the port that did not win last time gets the grant.
   always_comb begin
      winner_next = bus.p1_req;
      if (bus.p0_req && bus.p1_req) begin
         winner_next = ~lg_reg;
      end
      sel_rw    = winner_next ? bus.p1_rw    : bus.p0_rw;
      sel_addr  = winner_next ? bus.p1_addr  : bus.p0_addr;
      sel_wdata = winner_next ? bus.p1_wdata : bus.p0_wdata;
      sel_size  = winner_next ? bus.p1_size  : bus.p0_size;
      sel_invalid = (sel_size == 2'b10);
`ifdef MEM_ARB_ALIGN_CHECK_EN
      if (sel_size == 2'b11 && sel_addr[1:0] != 2'b00) begin
         sel_invalid = 1'b1;
      end
      if (sel_size == 2'b01 && sel_addr[0]) begin
         sel_invalid = 1'b1;
      end
`endif
   end

   // Byte lanes above the access size read back as zero, whatever the RAM drives.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         if (gi == 0) begin : g_byte
            assign lane_keep[gi] = 1'b1;
         end else if (gi == 1) begin : g_half
            assign lane_keep[gi] = mem_size_reg[0];
         end else begin : g_word
            assign lane_keep[gi] = &mem_size_reg;
         end
         assign rdata_masked[8*gi +: 8] = lane_keep[gi] ? bus.mem_rdata[8*gi +: 8] : 8'h00;
      end
   endgenerate

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_reg      <= IDLE;
         lg_reg         <= 1'b1;
         grant_reg      <= 1'b0;
         cnt_reg        <= 8'd0;
         mem_active_reg <= 1'b0;
         mem_rw_reg     <= 1'b0;
         mem_addr_reg   <= 9'd0;
         mem_wdata_reg  <= 32'd0;
         mem_size_reg   <= 2'd0;
         ack_reg        <= 2'b00;
         err_reg        <= 2'b00;
         rdata_reg      <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (bus.p0_req || bus.p1_req) begin
                  grant_reg     <= winner_next;
                  lg_reg        <= winner_next;
                  mem_rw_reg    <= sel_rw;
                  mem_addr_reg  <= sel_addr;
                  mem_wdata_reg <= sel_wdata;
                  mem_size_reg  <= sel_size;
                  if (sel_invalid) begin
                     state_reg             <= DONE;
                     ack_reg[winner_next]  <= 1'b1;
                     err_reg[winner_next]  <= 1'b1;
                  end else begin
                     state_reg      <= ACTIVE;
                     mem_active_reg <= 1'b1;
                     cnt_reg        <= 8'd0;
                  end
               end
            end
            ACTIVE: begin
               if (bus.mem_complete) begin
                  state_reg            <= DONE;
                  mem_active_reg       <= 1'b0;
                  ack_reg[grant_reg]   <= 1'b1;
                  rdata_reg[grant_reg] <= mem_rw_reg ? 32'd0 : rdata_masked;
               end else if (cnt_reg == CNT_LAST) begin
                  state_reg          <= DONE;
                  mem_active_reg     <= 1'b0;
                  ack_reg[grant_reg] <= 1'b1;
                  err_reg[grant_reg] <= 1'b1;
               end else begin
                  cnt_reg <= cnt_reg + 8'd1;
               end
            end
            DONE: begin
               state_reg <= IDLE;
               ack_reg   <= 2'b00;
               err_reg   <= 2'b00;
               rdata_reg <= '0;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign bus.p0_ack     = ack_reg[0];
   assign bus.p1_ack     = ack_reg[1];
   assign bus.p0_err     = err_reg[0];
   assign bus.p1_err     = err_reg[1];
   assign bus.p0_rdata   = rdata_reg[0];
   assign bus.p1_rdata   = rdata_reg[1];
   assign bus.mem_active = mem_active_reg;
   assign bus.mem_rw     = mem_rw_reg;
   assign bus.mem_addr   = mem_addr_reg;
   assign bus.mem_wdata  = mem_wdata_reg;
   assign bus.mem_size   = mem_size_reg;
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a behavioural RAM, per-port drivers that push
// predicted responses, and a monitor that pops and compares on every ack.
module tb_mem_arbiter;
   localparam int TIMEOUT = 16;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } resp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mem_arbiter_if ifc ();

   mem_arbiter #(.TIMEOUT(TIMEOUT)) dut (
      .Clk   (clk),
      .Reset (rst),
      .bus   (ifc.slave)
   );

   logic [7:0] ram [512];
   logic [7:0] model_mem [512];
   resp_t      exp_q0 [$];
   resp_t      exp_q1 [$];
   int         ack_port_log [$];
   int         ack_cyc_log [$];
   bit         stall = 1'b0;
   bit         ram_rand = 1'b0;
   int         active_rises = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   function automatic int nbytes(input logic [1:0] s);
      return (s == 2'b11) ? 4 : (s == 2'b01) ? 2 : 1;
   endfunction

   function automatic bit is_invalid(input logic [1:0] s, input logic [8:0] a);
      bit r;
      r = (s == 2'b10);
`ifdef MEM_ARB_ALIGN_CHECK_EN
      if (s == 2'b11 && a[1:0] != 2'b00) r = 1'b1;
      if (s == 2'b01 && a[0]) r = 1'b1;
`else
      if (a == 9'h1ff && s == 2'b10) r = 1'b1;
`endif
      return r;
   endfunction

   // Reference: an access either fails (err, zero data) or moves size bytes little-endian.
   function automatic resp_t predict(input bit rw, input logic [8:0] a, input logic [31:0] wd,
                                     input logic [1:0] s, input bit stalled);
      resp_t r;
      r.rdata = 32'd0;
      r.err   = 1'b0;
      if (is_invalid(s, a) || stalled) begin
         r.err = 1'b1;
         return r;
      end
      for (int b = 0; b < nbytes(s); b++) begin
         if (rw) model_mem[9'(int'(a) + b)] = wd[8*b +: 8];
         else    r.rdata[8*b +: 8] = model_mem[9'(int'(a) + b)];
      end
      return r;
   endfunction

   // Behavioural RAM: completes after a (possibly random) delay; byte/half reads carry stale upper bits.
   int          wait_cnt = 0;
   int          cur_delay = 0;
   bit          prev_active = 1'b0;
   logic [11:0] cap_ctl;
   logic [31:0] cap_wdata;
   always @(negedge clk) begin
      if (rst || !ifc.mem_active) begin
         ifc.mem_complete = 1'b0;
         wait_cnt = 0;
         cur_delay = ram_rand ? int'($urandom_range(0, 3)) : 0;
      end else begin
         if (!prev_active) begin
            active_rises++;
            cap_ctl   = {ifc.mem_rw, ifc.mem_size, ifc.mem_addr};
            cap_wdata = ifc.mem_wdata;
         end else begin
            check("mem_ctl_stable", 32'({ifc.mem_rw, ifc.mem_size, ifc.mem_addr}), 32'(cap_ctl));
            check("mem_wdata_stable", ifc.mem_wdata, cap_wdata);
         end
         if (ifc.mem_complete) begin
            ifc.mem_complete = 1'b0;
         end else if (!stall && wait_cnt >= cur_delay) begin
            if (ifc.mem_rw) begin
               for (int b = 0; b < nbytes(ifc.mem_size); b++)
                  ram[9'(int'(ifc.mem_addr) + b)] = ifc.mem_wdata[8*b +: 8];
            end else begin
               ifc.mem_rdata = $urandom;
               for (int b = 0; b < nbytes(ifc.mem_size); b++)
                  ifc.mem_rdata[8*b +: 8] = ram[9'(int'(ifc.mem_addr) + b)];
            end
            ifc.mem_complete = 1'b1;
         end else begin
            wait_cnt++;
         end
      end
      prev_active = rst ? 1'b0 : ifc.mem_active;
   end

   task automatic mon_port(input int p);
      resp_t e;
      logic [31:0] rd;
      logic er;
      rd = (p == 0) ? ifc.p0_rdata : ifc.p1_rdata;
      er = (p == 0) ? ifc.p0_err : ifc.p1_err;
      $display("txn port=%0d rdata=%h err=%0d cycle=%0d", p, rd, er, cyc);
      ack_port_log.push_back(p);
      ack_cyc_log.push_back(cyc);
      if ((p == 0 && exp_q0.size() == 0) || (p == 1 && exp_q1.size() == 0)) begin
         check($sformatf("unexpected_ack_p%0d", p), 32'd1, 32'd0);
         return;
      end
      e = (p == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
      check($sformatf("rdata_p%0d", p), rd, e.rdata);
      check($sformatf("err_p%0d", p), 32'(er), 32'(e.err));
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (ifc.p0_ack || ifc.p1_ack) begin
            check("single_ack", 32'(ifc.p0_ack & ifc.p1_ack), 32'd0);
            check("active_low_in_ack", 32'(ifc.mem_active), 32'd0);
         end
         if (ifc.p0_ack) mon_port(0);
         else check("p0_quiet", ifc.p0_rdata | 32'(ifc.p0_err), 32'd0);
         if (ifc.p1_ack) mon_port(1);
         else check("p1_quiet", ifc.p1_rdata | 32'(ifc.p1_err), 32'd0);
      end
   end

   // Called at posedge+1; returns ack latency in cycles from request assertion.
   task automatic drive_port(input int p, input bit rw, input logic [8:0] a,
                             input logic [31:0] wd, input logic [1:0] s, output int lat);
      resp_t r;
      int start;
      bit seen;
      r = predict(rw, a, wd, s, stall);
      if (p == 0) begin
         exp_q0.push_back(r);
         ifc.p0_rw = rw; ifc.p0_addr = a; ifc.p0_wdata = wd; ifc.p0_size = s; ifc.p0_req = 1'b1;
      end else begin
         exp_q1.push_back(r);
         ifc.p1_rw = rw; ifc.p1_addr = a; ifc.p1_wdata = wd; ifc.p1_size = s; ifc.p1_req = 1'b1;
      end
      start = cyc;
      seen = 1'b0;
      lat = -1;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge clk);
         if ((p == 0 && ifc.p0_ack) || (p == 1 && ifc.p1_ack)) begin
            seen = 1'b1;
            lat = cyc - start;
         end
      end
      check($sformatf("ack_arrived_p%0d", p), 32'(seen), 32'd1);
      @(posedge clk);
      #1;
      if (p == 0) ifc.p0_req = 1'b0;
      else        ifc.p1_req = 1'b0;
   endtask

   task automatic rand_traffic(input int p, input int base, input int n);
      int lat;
      logic [1:0] s;
      int pick;
      for (int i = 0; i < n; i++) begin
         pick = int'($urandom_range(0, 9));
         s = (pick == 0) ? 2'b10 : (pick < 4) ? 2'b00 : (pick < 7) ? 2'b01 : 2'b11;
         drive_port(p, 1'($urandom_range(0, 1)), 9'(base + int'($urandom_range(0, 200))),
                    $urandom, s, lat);
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: run exceeded time budget, bad=%0d", bad);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int lat;
      int lat0;
      int lat1;
      int rises;
      logic [7:0] v;
      for (int i = 0; i < 512; i++) begin
         v = 8'($urandom);
         ram[i] = v;
         model_mem[i] = v;
      end
      ifc.p0_req = 1'b0; ifc.p0_rw = 1'b0; ifc.p0_addr = 9'd0; ifc.p0_wdata = 32'd0; ifc.p0_size = 2'd0;
      ifc.p1_req = 1'b0; ifc.p1_rw = 1'b0; ifc.p1_addr = 9'd0; ifc.p1_wdata = 32'd0; ifc.p1_size = 2'd0;
      ifc.mem_rdata = 32'd0;
      ifc.mem_complete = 1'b0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ack_err", 32'({ifc.p1_err, ifc.p0_err, ifc.p1_ack, ifc.p0_ack}), 32'd0);
      check("rst_rdata0", ifc.p0_rdata, 32'd0);
      check("rst_rdata1", ifc.p1_rdata, 32'd0);
      check("rst_mem_ctl", 32'({ifc.mem_active, ifc.mem_rw, ifc.mem_size, ifc.mem_addr}), 32'd0);
      check("rst_mem_wdata", ifc.mem_wdata, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      drive_port(1, 1'b1, 9'd8, 32'hDEADBEEF, 2'b11, lat);
      check("wr_word_latency", 32'(lat), 32'd2);
      drive_port(1, 1'b0, 9'd8, 32'd0, 2'b11, lat);
      check("rd_word_latency", 32'(lat), 32'd2);
      drive_port(1, 1'b1, 9'd3, 32'h000000A5, 2'b00, lat);
      drive_port(1, 1'b0, 9'd3, 32'd0, 2'b00, lat);
      drive_port(1, 1'b0, 9'd8, 32'd0, 2'b01, lat);

      rises = active_rises;
      drive_port(0, 1'b0, 9'd20, 32'd0, 2'b10, lat);
      check("illegal_size_latency", 32'(lat), 32'd1);
      check("illegal_size_no_access", 32'(active_rises), 32'(rises));
`ifdef MEM_ARB_ALIGN_CHECK_EN
      drive_port(0, 1'b0, 9'd2, 32'd0, 2'b11, lat);
      check("misaligned_latency", 32'(lat), 32'd1);
      check("misaligned_no_access", 32'(active_rises), 32'(rises));
`endif

      stall = 1'b1;
      drive_port(0, 1'b0, 9'd16, 32'd0, 2'b11, lat);
      check("timeout_latency", 32'(lat), 32'(TIMEOUT + 1));
      stall = 1'b0;

      // Abandon an in-flight access with a one-cycle reset.
      stall = 1'b1;
      ifc.p1_rw = 1'b0; ifc.p1_addr = 9'd40; ifc.p1_size = 2'b11; ifc.p1_req = 1'b1;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      check("pre_reset_active", 32'(ifc.mem_active), 32'd1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      ifc.p1_req = 1'b0;
      stall = 1'b0;
      check("post_reset_idle", 32'({ifc.mem_active, ifc.p1_ack, ifc.p0_ack}), 32'd0);
      repeat (3) begin
         @(posedge clk);
         #1;
      end

      ack_port_log.delete();
      ack_cyc_log.delete();
      fork
         begin
            for (int i = 0; i < 4; i++) drive_port(0, 1'b0, 9'(i * 4), 32'd0, 2'b11, lat0);
         end
         begin
            for (int i = 0; i < 4; i++) drive_port(1, 1'b0, 9'(256 + i * 4), 32'd0, 2'b11, lat1);
         end
      join
      check("arb_ack_count", 32'(ack_port_log.size()), 32'd8);
      for (int i = 0; i < 8 && i < ack_port_log.size(); i++) begin
         check($sformatf("arb_order_%0d", i), 32'(ack_port_log[i]), 32'(i % 2));
         if (i > 0) check($sformatf("arb_spacing_%0d", i), 32'(ack_cyc_log[i] - ack_cyc_log[i-1]), 32'd3);
      end

      ram_rand = 1'b1;
      fork
         rand_traffic(0, 0, 40);
         rand_traffic(1, 256, 40);
      join
      repeat (5) @(posedge clk);
      check("q0_drained", 32'(exp_q0.size()), 32'd0);
      check("q1_drained", 32'(exp_q1.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
